fetch_pair_unit: RTL and testbench

Instruction-fetch stage of the dual-issue pipeline: owns the PC, fetches an aligned pair of 16-bit instructions per request from instruction memory over a req/ack handshake, and holds the IF/ID pipeline register. It obeys the `PCWrite`/`IF_ID_Write` stall outputs of the hazard detection unit, flushes on taken branches, and feeds back the decoded Rm/Rn/Rd fields of both IF/ID instructions to that unit.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/if_id_pipe_reg.sv | 57 +++++
 rtl/fetch_pair_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_pair_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

   typedef enum logic [1:0] {
      START   = 2'd0,
      FETCH   = 2'd1,
      FULL    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_t;

   localparam int INST_W     = 16;
   localparam int RD_LSB     = 0;
   localparam int RN_LSB     = 3;
   localparam int RM_LSB     = 6;
   localparam int FIELD_W    = 3;
   localparam int PAIR_BYTES = 4;

   localparam logic [INST_W-1:0] DEFAULT_NOP = 16'h0000;

   // One fetched word: inst1 in the low half, inst2 in the high half.
   typedef struct packed {
      logic [INST_W-1:0] inst2;
      logic [INST_W-1:0] inst1;
   } inst_pair_t;

   function automatic logic [FIELD_W-1:0] inst_field(input logic [INST_W-1:0] inst,
                                                     input int lsb);
      return inst[lsb +: FIELD_W];
   endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: instruction pair, its pc and a valid bit, plus register-field taps.
// Latency: one edge from load/flush to outputs; fields are combinational from the register.
// Backpressure: holds its contents whenever neither load nor flush is asserted.
//
// Ports: clk/rst; load (capture pair_in/pc_in, valid=1); flush (bubble, valid=0, wins over load);
//        inst1/inst2/pc/valid register outputs; inst{1,2}_{rd,rn,rm} decoded fields.
module if_id_pipe_reg
   import fetch_pkg::*;
#(
   parameter int                PC_W     = 16,
   parameter logic [INST_W-1:0] NOP_INST = DEFAULT_NOP
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               flush,
   input  inst_pair_t         pair_in,
   input  logic [PC_W-1:0]    pc_in,
   output logic [INST_W-1:0]  inst1,
   output logic [INST_W-1:0]  inst2,
   output logic [PC_W-1:0]    pc,
   output logic               valid,
   output logic [FIELD_W-1:0] inst1_rd,
   output logic [FIELD_W-1:0] inst1_rn,
   output logic [FIELD_W-1:0] inst1_rm,
   output logic [FIELD_W-1:0] inst2_rd,
   output logic [FIELD_W-1:0] inst2_rn,
   output logic [FIELD_W-1:0] inst2_rm
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst1 <= NOP_INST;
         inst2 <= NOP_INST;
         pc    <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         // pc is left alone on a bubble; it is only meaningful while valid.
         inst1 <= NOP_INST;
         inst2 <= NOP_INST;
         valid <= 1'b0;
      end else if (load) begin
         inst1 <= pair_in.inst1;
         inst2 <= pair_in.inst2;
         pc    <= pc_in;
         valid <= 1'b1;
      end
   end

   assign inst1_rd = inst_field(inst1, RD_LSB);
   assign inst1_rn = inst_field(inst1, RN_LSB);
   assign inst1_rm = inst_field(inst1, RM_LSB);
   assign inst2_rd = inst_field(inst2, RD_LSB);
   assign inst2_rn = inst_field(inst2, RN_LSB);
   assign inst2_rm = inst_field(inst2, RM_LSB);

endmodule

// File: rtl/fetch_pair_unit.sv
// Instruction fetch: owns the PC, fetches aligned 16-bit instruction pairs, drives IF/ID.
// Latency: IF/ID loads on the edge that samples imem_ack when not stalled; redirect next cycle.
// Backpressure: a pair acked during a stall is parked in a skid register and imem_req drops.
//
// Ports: clk/rst; PCWrite/IF_ID_Write stall enables; branch_taken/branch_target redirect;
//        imem_req/imem_addr/imem_ack/imem_rdata memory handshake; IF_ID_* register outputs
//        and decoded Rd/Rn/Rm fields of both IF/ID instructions.
module fetch_pair_unit
   import fetch_pkg::*;
#(
   parameter int                PC_W     = 16,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter logic [INST_W-1:0] NOP_INST = DEFAULT_NOP
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               PCWrite,
   input  logic               IF_ID_Write,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic [INST_W-1:0]  IF_ID_inst1,
   output logic [INST_W-1:0]  IF_ID_inst2,
   output logic [PC_W-1:0]    IF_ID_pc,
   output logic               IF_ID_valid,
   output logic [FIELD_W-1:0] IF_ID_inst1_Rd,
   output logic [FIELD_W-1:0] IF_ID_inst1_Rn,
   output logic [FIELD_W-1:0] IF_ID_inst1_Rm,
   output logic [FIELD_W-1:0] IF_ID_inst2_Rd,
   output logic [FIELD_W-1:0] IF_ID_inst2_Rn,
   output logic [FIELD_W-1:0] IF_ID_inst2_Rm
);

   localparam logic [PC_W-1:0] PC_STEP    = PC_W'(PAIR_BYTES);
   localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(PAIR_BYTES - 1);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] disc_addr_q, disc_addr_d;
   logic            skid_vld_q, skid_vld_d;
   inst_pair_t      skid_q, skid_d;

   logic            both_en;
   logic            ifid_load, ifid_flush;
   inst_pair_t      ifid_pair;
   logic [PC_W-1:0] tgt_aligned;

   assign both_en     = PCWrite & IF_ID_Write;
   assign tgt_aligned = branch_target & ALIGN_MASK;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      disc_addr_d = disc_addr_q;
      skid_vld_d  = skid_vld_q;
      skid_d      = skid_q;
      ifid_load   = 1'b0;
      ifid_flush  = 1'b0;
      ifid_pair   = imem_rdata;
      imem_req    = 1'b0;

      unique case (state_q)
         START: state_d = FETCH;

         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               if (both_en) begin
                  ifid_load = 1'b1;
                  pc_d      = pc_q + PC_STEP;
               end else begin
                  // PC still points at the parked pair; it advances on release.
                  skid_vld_d = 1'b1;
                  skid_d     = imem_rdata;
                  state_d    = FULL;
               end
            end else if (IF_ID_Write) begin
               ifid_flush = 1'b1;
            end
         end

         FULL: begin
            if (both_en && skid_vld_q) begin
               ifid_load  = 1'b1;
               ifid_pair  = skid_q;
               skid_vld_d = 1'b0;
               pc_d       = pc_q + PC_STEP;
               state_d    = FETCH;
            end
         end

         DISCARD: begin
            imem_req = 1'b1;
            if (imem_ack) state_d = FETCH;
         end

         default: state_d = START;
      endcase

      // A redirect overrides everything above, stall enables included.
      if (branch_taken) begin
         pc_d       = tgt_aligned;
         ifid_load  = 1'b0;
         ifid_flush = 1'b1;
         skid_vld_d = 1'b0;
         if (imem_req && !imem_ack) begin
            // The memory still owes us the old request; keep presenting its
            // address until the ack arrives, then throw the data away.
            state_d = DISCARD;
            if (state_q == FETCH) disc_addr_d = pc_q;
         end else begin
            state_d = FETCH;
         end
      end
   end

   assign imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= START;
         pc_q        <= RESET_PC;
         disc_addr_q <= '0;
         skid_vld_q  <= 1'b0;
         skid_q      <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         disc_addr_q <= disc_addr_d;
         skid_vld_q  <= skid_vld_d;
         skid_q      <= skid_d;
      end
   end

   if_id_pipe_reg #(
      .PC_W     (PC_W),
      .NOP_INST (NOP_INST)
   ) u_if_id (
      .clk      (clk),
      .rst      (rst),
      .load     (ifid_load),
      .flush    (ifid_flush),
      .pair_in  (ifid_pair),
      .pc_in    (pc_q),
      .inst1    (IF_ID_inst1),
      .inst2    (IF_ID_inst2),
      .pc       (IF_ID_pc),
      .valid    (IF_ID_valid),
      .inst1_rd (IF_ID_inst1_Rd),
      .inst1_rn (IF_ID_inst1_Rn),
      .inst1_rm (IF_ID_inst1_Rm),
      .inst2_rd (IF_ID_inst2_Rd),
      .inst2_rn (IF_ID_inst2_Rn),
      .inst2_rm (IF_ID_inst2_Rm)
   );

endmodule

// File: tb/tb_fetch_pair_unit.sv
// Bench for fetch_pair_unit: directed vectors, transaction-level reference model, per-cycle compare.
// Latency: n/a.
// Backpressure: memory acks only when the stimulus enables it.
module tb_fetch_pair_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_write = 1'b1;
   logic        ifid_write = 1'b1;
   logic        br_taken = 1'b0;
   logic [15:0] br_target = '0;
   logic        ack_en = 1'b0;

   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [15:0] if_inst1, if_inst2, if_pc;
   logic        if_valid;
   logic [2:0]  i1_rd, i1_rn, i1_rm, i2_rd, i2_rn, i2_rm;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {~a, a + 16'h01CA};
   endfunction

   assign imem_ack   = ack_en & imem_req;
   assign imem_rdata = mem_word(imem_addr);

   fetch_pair_unit #(.PC_W(16), .RESET_PC(16'h0000), .NOP_INST(16'h0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .PCWrite        (pc_write),
      .IF_ID_Write    (ifid_write),
      .branch_taken   (br_taken),
      .branch_target  (br_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .IF_ID_inst1    (if_inst1),
      .IF_ID_inst2    (if_inst2),
      .IF_ID_pc       (if_pc),
      .IF_ID_valid    (if_valid),
      .IF_ID_inst1_Rd (i1_rd),
      .IF_ID_inst1_Rn (i1_rn),
      .IF_ID_inst1_Rm (i1_rm),
      .IF_ID_inst2_Rd (i2_rd),
      .IF_ID_inst2_Rn (i2_rn),
      .IF_ID_inst2_Rm (i2_rm)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit          m_gap;        // a request-free cycle is still owed after reset
   logic [15:0] m_pc;         // next address to fetch
   bit          m_dropping;   // an in-flight request whose data will be thrown away
   logic [15:0] m_drop_addr;
   logic [31:0] m_held[$];    // acked pairs waiting for the stall to clear
   logic [15:0] m_i1, m_i2, m_ipc;
   bit          m_valid;

   function automatic bit exp_req();
      return !m_gap && (m_held.size() == 0);
   endfunction

   function automatic logic [15:0] exp_addr();
      return m_dropping ? m_drop_addr : m_pc;
   endfunction

   task automatic model_reset();
      m_gap = 1; m_pc = 16'h0000; m_dropping = 0; m_drop_addr = '0;
      m_held.delete();
      m_i1 = 16'h0000; m_i2 = 16'h0000; m_ipc = '0; m_valid = 0;
   endtask

   task automatic bubble();
      m_i1 = 16'h0000; m_i2 = 16'h0000; m_valid = 0;
   endtask

   task automatic deliver(input logic [31:0] w);
      m_i1 = w[15:0]; m_i2 = w[31:16]; m_ipc = m_pc; m_valid = 1;
      m_pc = m_pc + 16'd4;
   endtask

   task automatic model_advance();
      bit          req, ack, go;
      logic [31:0] data;
      req  = exp_req();
      ack  = req && ack_en;
      data = mem_word(exp_addr());
      go   = pc_write && ifid_write;
      if (br_taken) begin
         if (req && !ack && !m_dropping) begin
            m_dropping = 1; m_drop_addr = m_pc;
         end else if (ack) begin
            m_dropping = 0;
         end
         m_pc  = br_target & 16'hFFFC;
         m_gap = 0;
         m_held.delete();
         bubble();
      end else if (m_gap) begin
         m_gap = 0;
      end else if (m_held.size() != 0) begin
         if (go) deliver(m_held.pop_front());
      end else if (m_dropping) begin
         if (ack) m_dropping = 0;
      end else if (ack) begin
         if (go) deliver(data);
         else m_held.push_back(data);
      end else if (ifid_write) begin
         bubble();
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req()});
         if (exp_req()) chk("imem_addr", {16'd0, imem_addr}, {16'd0, exp_addr()});
         chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
         chk("if_inst1", {16'd0, if_inst1}, {16'd0, m_i1});
         chk("if_inst2", {16'd0, if_inst2}, {16'd0, m_i2});
         if (m_valid) chk("if_pc", {16'd0, if_pc}, {16'd0, m_ipc});
         chk("fields", {14'd0, i1_rd, i1_rn, i1_rm, i2_rd, i2_rn, i2_rm},
             {14'd0, m_i1[2:0], m_i1[5:3], m_i1[8:6], m_i2[2:0], m_i2[5:3], m_i2[8:6]});
      end
   end

   // One clock: apply inputs, advance the model on the edge, return 1 time unit later.
   task automatic cyc(input bit ack, input bit pcw, input bit ifw, input bit br,
                      input logic [15:0] tgt);
      ack_en = ack; pc_write = pcw; ifid_write = ifw; br_taken = br; br_target = tgt;
      @(posedge clk);
      if (rst) model_reset();
      else model_advance();
      #1;
   endtask

   logic [19:0] tbl [0:13];

   initial begin
      tbl[0]  = {4'b1110, 16'h0000};
      tbl[1]  = {4'b0010, 16'h0000};
      tbl[2]  = {4'b1010, 16'h0000};
      tbl[3]  = {4'b0110, 16'h0000};
      tbl[4]  = {4'b0001, 16'h0123};
      tbl[5]  = {4'b0000, 16'h0000};
      tbl[6]  = {4'b1110, 16'h0000};
      tbl[7]  = {4'b0111, 16'h0200};
      tbl[8]  = {4'b0001, 16'h0300};
      tbl[9]  = {4'b1110, 16'h0000};
      tbl[10] = {4'b1100, 16'h0000};
      tbl[11] = {4'b1110, 16'h0000};
      tbl[12] = {4'b1110, 16'h0000};
      tbl[13] = {4'b0010, 16'h0000};

      model_reset();
      rst = 1'b1;
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      rst = 1'b0;
      #1;
      // Reset state, START cycle.
      chk("lit_reset_req", {31'd0, imem_req}, 32'd0);
      chk("lit_reset_valid", {31'd0, if_valid}, 32'd0);
      chk("lit_reset_inst1", {16'd0, if_inst1}, 32'h0000);

      // Back-to-back fetches with same-cycle ack.
      cyc(1, 1, 1, 0, 0);
      chk("lit_first_req", {31'd0, imem_req}, 32'd1);
      chk("lit_first_addr", {16'd0, imem_addr}, 32'h0000);
      cyc(1, 1, 1, 0, 0);
      chk("lit_pc0", {16'd0, if_pc}, 32'h0000);
      chk("lit_valid0", {31'd0, if_valid}, 32'd1);
      chk("lit_inst1_0", {16'd0, if_inst1}, 32'h01CA);
      chk("lit_fields_0", {23'd0, i1_rd, i1_rn, i1_rm}, {23'd0, 3'd2, 3'd1, 3'd7});
      chk("lit_addr4", {16'd0, imem_addr}, 32'h0004);
      cyc(1, 1, 1, 0, 0);
      chk("lit_pc4", {16'd0, if_pc}, 32'h0004);
      chk("lit_addr8", {16'd0, imem_addr}, 32'h0008);

      // Three stall cycles, ack arrives during the stall.
      cyc(0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("lit_full_req", {31'd0, imem_req}, 32'd0);
      chk("lit_full_hold_pc", {16'd0, if_pc}, 32'h0004);
      cyc(1, 0, 0, 0, 0);
      chk("lit_full_req2", {31'd0, imem_req}, 32'd0);
      cyc(1, 1, 1, 0, 0);
      chk("lit_release_pc", {16'd0, if_pc}, 32'h0008);
      chk("lit_release_inst1", {16'd0, if_inst1}, 32'h01D2);
      chk("lit_release_addr", {16'd0, imem_addr}, 32'h000C);

      // Branch while a request to 0x0010 is unacked.
      cyc(1, 1, 1, 0, 0);
      chk("lit_addr10", {16'd0, imem_addr}, 32'h0010);
      cyc(0, 1, 1, 1, 16'h0043);
      chk("lit_br_valid", {31'd0, if_valid}, 32'd0);
      chk("lit_discard_addr", {16'd0, imem_addr}, 32'h0010);
      cyc(0, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      chk("lit_after_discard_valid", {31'd0, if_valid}, 32'd0);
      chk("lit_br_target_addr", {16'd0, imem_addr}, 32'h0040);
      cyc(1, 1, 1, 0, 0);
      chk("lit_pc40", {16'd0, if_pc}, 32'h0040);

      // Branch and ack in the same cycle.
      cyc(1, 1, 1, 1, 16'h0080);
      chk("lit_brack_valid", {31'd0, if_valid}, 32'd0);
      chk("lit_brack_addr", {16'd0, imem_addr}, 32'h0080);
      cyc(1, 1, 1, 0, 0);
      chk("lit_pc80", {16'd0, if_pc}, 32'h0080);

      // PC wrap at the top of the address space.
      cyc(1, 1, 1, 1, 16'hFFFC);
      cyc(1, 1, 1, 0, 0);
      chk("lit_pcFFFC", {16'd0, if_pc}, 32'hFFFC);
      chk("lit_wrap_addr", {16'd0, imem_addr}, 32'h0000);
      chk("lit_wrap_req", {31'd0, imem_req}, 32'd1);

      // Asynchronous reset in the middle of a request.
      rst = 1'b1;
      model_reset();
      #1;
      chk("lit_rst_req_drop", {31'd0, imem_req}, 32'd0);
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);
      rst = 1'b0;
      #1;
      chk("lit_rst_start_req", {31'd0, imem_req}, 32'd0);
      cyc(0, 1, 1, 0, 0);
      chk("lit_rst_fetch_req", {31'd0, imem_req}, 32'd1);
      chk("lit_rst_fetch_addr", {16'd0, imem_addr}, 32'h0000);

      // Mixed stalls, bubbles, branches from FULL and DISCARD.
      for (int i = 0; i < 14; i++) begin
         logic [19:0] v;
         v = tbl[i];
         cyc(v[19], v[18], v[17], v[16], v[15:0]);
      end
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
